// File: rtl/fifo_n_count.sv
// fifo_n_count: parametrised-depth synchronous FIFO with occupancy count,
// programmable almost-full flag and sticky protocol-error flag.
// The head entry lives in the D_OUT register; entries 2..count live in a
// (depth-1)-entry circular buffer addressed by rd_ptr/wr_ptr.
module fifo_n_count #(
    parameter int width        = 1,
    parameter int depth        = 4,
    parameter int cntwidth     = 3,
    parameter int afull_margin = 1,
    parameter bit guarded      = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [width-1:0]    D_IN,
    input  logic                ENQ,
    input  logic                DEQ,
    input  logic                CLR,
    output logic [width-1:0]    D_OUT,
    output logic                FULL_N,
    output logic                EMPTY_N,
    output logic                ALMOST_FULL_N,
    output logic [cntwidth-1:0] COUNT,
    output logic                ERR
);

    // Pointer width for the (depth-1)-entry buffer; at least one bit.
    localparam int PW = (depth - 1 > 1) ? $clog2(depth - 1) : 1;

    localparam logic [PW-1:0]       PTR_LAST  = PW'(depth - 2);
    localparam logic [cntwidth-1:0] CNT_FULL  = cntwidth'(depth);
    localparam logic [cntwidth-1:0] CNT_AFULL = cntwidth'(depth - afull_margin);
    localparam logic [cntwidth-1:0] CNT_ONE   = cntwidth'(1);

    // Reject parameter sets the storage scheme cannot support.
    generate
        if (depth < 2 || (1 << cntwidth) <= depth || afull_margin >= depth || afull_margin < 0) begin : g_bad_params
            $error("fifo_n_count: illegal parameters depth=%0d cntwidth=%0d afull_margin=%0d",
                   depth, cntwidth, afull_margin);
        end
    endgenerate

    logic [width-1:0]    mem [0:depth-2];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [cntwidth-1:0] count;

    logic is_full, is_empty, is_one;
    logic do_enq, do_deq, err_set;
    logic [PW-1:0] rd_ptr_inc, wr_ptr_inc;

    assign is_full  = (count == CNT_FULL);
    assign is_empty = (count == '0);
    assign is_one   = (count == CNT_ONE);

    // Pointer increment with wrap at depth-2 (buffer size need not be a power of two).
    assign rd_ptr_inc = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
    assign wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);

    // Decide which requests take effect this cycle and whether the protocol was violated.
    always_comb begin
        do_deq  = DEQ && !is_empty;
        do_enq  = ENQ && (!is_full || (DEQ && !guarded));
        err_set = (DEQ && is_empty) || (ENQ && is_full && !(DEQ && !guarded));
    end

    // Count, pointers, head register and error flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            D_OUT  <= '0;
            ERR    <= 1'b0;
        end else if (CLR) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            ERR    <= 1'b0;
        end else begin
            if (err_set)
                ERR <= 1'b1;
            if (do_enq && !do_deq) begin
                count <= count + CNT_ONE;
                if (is_empty)
                    D_OUT <= D_IN;
                else
                    wr_ptr <= wr_ptr_inc;
            end else if (do_deq && !do_enq) begin
                count <= count - CNT_ONE;
                if (!is_one) begin
                    D_OUT  <= mem[rd_ptr];
                    rd_ptr <= rd_ptr_inc;
                end
            end else if (do_enq && do_deq) begin
                // Occupancy unchanged; head advances, tail appends.
                if (is_one) begin
                    D_OUT <= D_IN;
                end else begin
                    D_OUT  <= mem[rd_ptr];
                    rd_ptr <= rd_ptr_inc;
                    wr_ptr <= wr_ptr_inc;
                end
            end
        end
    end

    // Buffer write: only when the new entry does not go straight into the head register.
    always_ff @(posedge CLK) begin
        if (!RST && !CLR && do_enq && !is_empty && !(do_deq && is_one))
            mem[wr_ptr] <= D_IN;
    end

    // Status flags decoded from the count register only.
    always_comb begin
        COUNT         = count;
        FULL_N        = !is_full;
        EMPTY_N       = !is_empty;
        ALMOST_FULL_N = (count < CNT_AFULL);
    end

endmodule

// File: tb/tb_fifo_n_count.sv
// Directed testbench for fifo_n_count: two instances share stimulus, one
// unguarded (A) and one guarded (B), with hand-computed expectations.
module tb_fifo_n_count;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] D_IN = '0;
    logic       ENQ = 1'b0;
    logic       DEQ = 1'b0;
    logic       CLR = 1'b0;

    logic [7:0] a_dout, b_dout;
    logic       a_full_n, a_empty_n, a_afull_n, a_err;
    logic       b_full_n, b_empty_n, b_afull_n, b_err;
    logic [2:0] a_count, b_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    fifo_n_count #(.width(8), .depth(4), .cntwidth(3), .afull_margin(1), .guarded(1'b0)) u_a (
        .CLK(CLK), .RST(RST), .D_IN(D_IN), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
        .D_OUT(a_dout), .FULL_N(a_full_n), .EMPTY_N(a_empty_n),
        .ALMOST_FULL_N(a_afull_n), .COUNT(a_count), .ERR(a_err)
    );

    fifo_n_count #(.width(8), .depth(4), .cntwidth(3), .afull_margin(1), .guarded(1'b1)) u_b (
        .CLK(CLK), .RST(RST), .D_IN(D_IN), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
        .D_OUT(b_dout), .FULL_N(b_full_n), .EMPTY_N(b_empty_n),
        .ALMOST_FULL_N(b_afull_n), .COUNT(b_count), .ERR(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of requests; returns 1 time unit after the edge.
    task automatic cyc(input logic e, input logic d, input logic c, input logic [7:0] din);
        ENQ = e; DEQ = d; CLR = c; D_IN = din;
        @(posedge CLK);
        #1;
        ENQ = 1'b0; DEQ = 1'b0; CLR = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic [2:0] cnt, input logic [7:0] dout, input logic err);
        chk({tag, " A.COUNT"}, 32'(a_count), 32'(cnt));
        chk({tag, " A.D_OUT"}, 32'(a_dout), 32'(dout));
        chk({tag, " A.ERR"}, 32'(a_err), 32'(err));
    endtask

    task automatic chk_b(input string tag, input logic [2:0] cnt, input logic [7:0] dout, input logic err);
        chk({tag, " B.COUNT"}, 32'(b_count), 32'(cnt));
        chk({tag, " B.D_OUT"}, 32'(b_dout), 32'(dout));
        chk({tag, " B.ERR"}, 32'(b_err), 32'(err));
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, " D_OUT"}, 32'(a_dout), 32'h0);
        chk({tag, " FULL_N"}, 32'(a_full_n), 32'h1);
        chk({tag, " EMPTY_N"}, 32'(a_empty_n), 32'h0);
        chk({tag, " AFULL_N"}, 32'(a_afull_n), 32'h1);
        chk({tag, " COUNT"}, 32'(a_count), 32'h0);
        chk({tag, " ERR"}, 32'(a_err), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        // Reset state, checked while RST is still held.
        #3;
        chk_rst("reset");
        @(negedge CLK);
        RST = 1'b0;

        // Fill / drain with flag checks.
        cyc(1, 0, 0, 8'h11); chk_a("fill1", 3'd1, 8'h11, 0); chk("fill1 EMPTY_N", 32'(a_empty_n), 32'h1);
        chk("fill1 AFULL_N", 32'(a_afull_n), 32'h1);
        cyc(1, 0, 0, 8'h22); chk_a("fill2", 3'd2, 8'h11, 0); chk("fill2 AFULL_N", 32'(a_afull_n), 32'h1);
        cyc(1, 0, 0, 8'h33); chk_a("fill3", 3'd3, 8'h11, 0); chk("fill3 AFULL_N", 32'(a_afull_n), 32'h0);
        chk("fill3 FULL_N", 32'(a_full_n), 32'h1);
        cyc(1, 0, 0, 8'h44); chk_a("fill4", 3'd4, 8'h11, 0); chk("fill4 FULL_N", 32'(a_full_n), 32'h0);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 1, 0, 8'h00);
            chk_a("drain", 3'(4 - i), fill[i], 0);
        end
        cyc(0, 1, 0, 8'h00);
        chk_a("drain4", 3'd0, 8'h44, 0);
        chk("drain4 EMPTY_N", 32'(a_empty_n), 32'h0);
        chk("drain4 FULL_N", 32'(a_full_n), 32'h1);

        // Steady streaming at COUNT=2; pointers wrap several times.
        cyc(1, 0, 0, 8'hAA);
        cyc(1, 0, 0, 8'hBB); chk_a("pre-stream", 3'd2, 8'hAA, 0);
        cyc(1, 1, 0, 8'h00); chk_a("stream0", 3'd2, 8'hBB, 0);
        for (int k = 1; k < 10; k++) begin
            cyc(1, 1, 0, 8'(k));
            chk_a("stream", 3'd2, 8'(k - 1), 0);
        end
        cyc(0, 1, 0, 8'h00); chk_a("post-stream", 3'd1, 8'h09, 0);
        cyc(0, 1, 0, 8'h00); chk_a("post-stream-empty", 3'd0, 8'h09, 0);

        // Full simultaneous ENQ+DEQ: A passes through, B drops the enqueue.
        for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 8'(i));
        chk_a("full", 3'd4, 8'h01, 0);
        chk_b("full", 3'd4, 8'h01, 0);
        cyc(1, 1, 0, 8'h55);
        chk_a("fullsim", 3'd4, 8'h02, 0);
        chk_b("fullsim", 3'd3, 8'h02, 1);
        cyc(0, 1, 0, 8'h00); chk_a("fs-d1", 3'd3, 8'h03, 0); chk_b("fs-d1", 3'd2, 8'h03, 1);
        cyc(0, 1, 0, 8'h00); chk_a("fs-d2", 3'd2, 8'h04, 0); chk_b("fs-d2", 3'd1, 8'h04, 1);
        cyc(0, 1, 0, 8'h00); chk_a("fs-d3", 3'd1, 8'h55, 0); chk_b("fs-d3", 3'd0, 8'h04, 1);
        cyc(0, 1, 0, 8'h00); chk_a("fs-d4", 3'd0, 8'h55, 0); chk_b("fs-d4", 3'd0, 8'h04, 1);

        // CLR clears ERR and COUNT, D_OUT holds.
        cyc(0, 0, 1, 8'h00);
        chk_b("clr1", 3'd0, 8'h04, 0);

        // Underflow, overflow, then CLR.
        cyc(0, 1, 0, 8'h00); chk_a("underflow", 3'd0, 8'h55, 1);
        for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 8'(8'h60 + i));
        cyc(1, 0, 0, 8'h99); chk_a("overflow", 3'd4, 8'h61, 1);
        cyc(0, 1, 0, 8'h00); chk_a("of-d1", 3'd3, 8'h62, 1);
        cyc(0, 1, 0, 8'h00); chk_a("of-d2", 3'd2, 8'h63, 1);
        cyc(0, 1, 0, 8'h00); chk_a("of-d3", 3'd1, 8'h64, 1);
        cyc(0, 1, 0, 8'h00); chk_a("of-d4", 3'd0, 8'h64, 1);
        cyc(0, 0, 1, 8'h00); chk_a("clr2", 3'd0, 8'h64, 0);

        // Empty simultaneous ENQ+DEQ: enqueue only, flagged.
        cyc(1, 1, 0, 8'h7A); chk_a("emptysim", 3'd1, 8'h7A, 1);
        chk("emptysim EMPTY_N", 32'(a_empty_n), 32'h1);

        // Async reset mid-cycle with three entries held.
        cyc(0, 0, 1, 8'h00);
        cyc(1, 0, 0, 8'h01);
        cyc(1, 0, 0, 8'h02);
        cyc(1, 0, 0, 8'h03); chk_a("pre-rst", 3'd3, 8'h01, 0);
        #2 RST = 1'b1;
        #1 chk_rst("async-rst");
        #1 RST = 1'b0;
        cyc(1, 0, 0, 8'h01); chk_a("post-rst", 3'd1, 8'h01, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
